// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port (we3/wa3/wd3) among NREQ
// writeback requesters. Arbitration is round-robin. A granted requester can
// lock the port to issue a back-to-back burst. All write-port outputs are
// registered, so there is one cycle of latency from a sampled req to gnt/we3.
//
// Optional feature: define RF_ARB_FWD_EN to add a combinational read bypass
// of the in-flight write (ra1/ra2, rd1_in/rd2_in -> rd1_fwd/rd2_fwd).
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-high; clears all state
//   req        per-requester request; held until that requester's gnt
//   req_lock   requester asks to keep the port after its grant
//   req_addr   destination register, requester i at [i*AW +: AW]
//   req_data   write data, requester i at [i*DW +: DW]
//   gnt        one-hot; high for the cycle the requester's write is on the port
//   we3        register-file write enable (never set for register 0)
//   wa3        register-file write address
//   wd3        register-file write data
//   busy       same as we3
//   arb_state  0 IDLE, 1 ARB, 2 LOCKED
//   ra1, ra2, rd1_in, rd2_in, rd1_fwd, rd2_fwd   (RF_ARB_FWD_EN only)
//
// State table:
//   IDLE   | no grant was issued on the last edge
//   ARB    | an unlocked grant was issued on the last edge
//   LOCKED | r_owner holds the port; only it may be granted
module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  output logic                 busy,
  output logic [1:0]           arb_state
`ifdef RF_ARB_FWD_EN
  ,
  input  logic [AW-1:0]        ra1,
  input  logic [AW-1:0]        ra2,
  input  logic [DW-1:0]        rd1_in,
  input  logic [DW-1:0]        rd2_in,
  output logic [DW-1:0]        rd1_fwd,
  output logic [DW-1:0]        rd2_fwd
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARB    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [NREQ-1:0] r_gnt;
  logic            r_we3;
  logic [AW-1:0]   r_wa3;
  logic [DW-1:0]   r_wd3;

  logic            w_rr_found;
  logic [PW-1:0]   w_rr_win;
  logic            w_lock_hold;
  logic            w_grant;
  logic [PW-1:0]   w_win;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [PW-1:0]   w_ptr_nxt;

  // First requester at or after the pointer, wrapping mod NREQ.
  always_comb begin : rr_search
    int idx;
    idx        = 0;
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_rr_found && req[idx]) begin
        w_rr_found = 1'b1;
        w_rr_win   = PW'(idx);
      end
    end
  end

  // While the owner keeps req_lock high nobody else can win, even when the
  // owner has nothing to write this cycle. Once it drops req_lock the pointer
  // already sits at owner+1, so normal arbitration applies on the same edge.
  assign w_lock_hold = (r_state == S_LOCKED) && req_lock[r_owner];
  assign w_grant     = w_lock_hold ? req[r_owner] : w_rr_found;
  assign w_win       = w_lock_hold ? r_owner      : w_rr_win;
  assign w_addr      = req_addr[int'(w_win)*AW +: AW];
  assign w_data      = req_data[int'(w_win)*DW +: DW];
  assign w_ptr_nxt   = PW'((int'(w_win) + 1) % NREQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_we3   <= 1'b0;
      r_wa3   <= '0;
      r_wd3   <= '0;
    end else begin
      r_gnt <= '0;
      r_we3 <= 1'b0;
      if (w_grant) begin
        r_gnt <= NREQ'(1) << w_win;
        // Register 0 is hardwired zero: grant the slot but suppress the write.
        r_we3 <= (w_addr != '0);
        r_wa3 <= w_addr;
        r_wd3 <= w_data;
        r_ptr <= w_ptr_nxt;
      end

      if (w_lock_hold) begin
        r_state <= S_LOCKED;
      end else if (w_grant && req_lock[w_win]) begin
        r_state <= S_LOCKED;
        r_owner <= w_win;
      end else if (w_grant) begin
        r_state <= S_ARB;
        r_owner <= '0;
      end else begin
        r_state <= S_IDLE;
        r_owner <= '0;
      end
    end
  end

  assign gnt       = r_gnt;
  assign we3       = r_we3;
  assign wa3       = r_wa3;
  assign wd3       = r_wd3;
  assign busy      = r_we3;
  assign arb_state = r_state;

`ifdef RF_ARB_FWD_EN
  assign rd1_fwd = (r_we3 && (r_wa3 == ra1) && (ra1 != '0)) ? r_wd3 : rd1_in;
  assign rd2_fwd = (r_we3 && (r_wa3 == ra2) && (ra2 != '0)) ? r_wd3 : rd2_in;
`endif

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-file write port (we3/wa3/wd3) among NREQ writeback requesters, e.g. ALU result, I/O input port and load unit. It uses round-robin arbitration with an optional lock, so one requester can hold the port for a back-to-back burst. Write-port outputs are registered and drive the 16x8 register bank directly, giving a sustained throughput of one write per cycle.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width (matches register width)
AW, 4, register address width (16 registers)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state
req  input  NREQ  request per requester; hold until gnt
req_lock  input  NREQ  requester asks to keep port after its grant
req_addr  input  NREQ*AW  destination register, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  write data, requester i at [i*DW +: DW]
gnt  output  NREQ  one-hot; high for exactly the cycle its write is on the port
we3  output  1  register-file write enable
wa3  output  AW  register-file write address
wd3  output  DW  register-file write data
busy  output  1  equals we3
arb_state  output  2  FSM state: 0 IDLE, 1 ARB, 2 LOCKED

Behaviour:
- Reset (async): gnt=0, we3=0, wa3=0, wd3=0, busy=0, arb_state=IDLE, rr pointer=0, lock owner cleared.
- Each rising edge samples req. A winner is chosen and registered into gnt/wa3/wd3/we3. Latency is one cycle from req sampled to gnt/we3 high, and the register bank writes at the end of the gnt cycle.
- Round-robin: search starts at pointer p, taking the first i in p, p+1, ... mod NREQ with req[i]=1. After an unlocked grant to i, p becomes (i+1) mod NREQ. With no requests, p is unchanged.
- Handshake: the requester keeps req/addr/data stable until the cycle gnt[i]=1. A req still high when sampled at the end of the gnt cycle counts as a new request.
- Only one gnt bit is ever high. gnt is all-zero when no write is issued.
- Address 0: the grant is issued normally (gnt pulses, pointer advances), but we3 stays 0 because register 0 is hardwired zero.
- FSM:
  - IDLE: no request sampled. On any req, go to ARB, or to LOCKED if the winner has req_lock=1.
  - ARB: a grant was issued. Next winner per round-robin. Go to LOCKED if the winner's req_lock=1, or to IDLE if no req.
  - LOCKED: only the owner may win. While the owner has req_lock=1, its req=1 grants every cycle and its req=0 gives an idle cycle with no grant to others. The owner dropping req_lock (sampled) releases the lock: that same edge arbitrates normally with p = owner+1 and goes to ARB or IDLE.
- Lock is held only by a granted requester. req_lock without req has no effect.
- Reset mid-burst: the lock is dropped, outputs clear immediately, and no partial write occurs after reset deasserts.
- Widths: wa3/wd3 are copied bit-exact with no arithmetic. NREQ not a power of 2 uses mod NREQ wrap.

Optional Feature:
RF_ARB_FWD_EN: adds inputs ra1, ra2 (AW) and rd1_in, rd2_in (DW), plus outputs rd1_fwd, rd2_fwd (DW).
- When enabled: rd1_fwd = wd3 if we3 and wa3==ra1 and ra1!=0, else rd1_in. rd2_fwd is the same using ra2/rd2_in. This is combinational bypass of the in-flight write.
- When disabled: the ports are absent and no forwarding logic exists.

Test Plan:
- Reset, then req=0 for 5 cycles -> gnt=0, we3=0, arb_state=IDLE, p=0.
- req=4'b1111 held continuously, addrs 1..4, data A0..A3 -> grants 0,1,2,3,0 on consecutive cycles, we3=1 every cycle, wa3 sequence 1,2,3,4,1.
- req[2]=1 with req_lock[2]=1 for 3 writes while req[0]=1 -> three gnt[2] pulses with no gnt[0]. Then lock drops -> gnt[0] next, state ARB.
- req[1]=1 with addr=0, data=FF -> gnt[1] pulses, we3=0, the register bank is unchanged, and p advances to 2.
- Reset asserted during LOCKED burst -> outputs 0 asynchronously. After release with req[3]=1 only -> gnt[3] after one cycle, state ARB not LOCKED unless req_lock[3]=1.
- FWD_EN: write reg 5=3C while ra1=5 and rd1_in=00 -> rd1_fwd=3C in the gnt cycle; with ra1=0 -> rd1_fwd=rd1_in.
